gsu_cache_ctrl: RTL

GSU_CACHE_CTRL -- requirements
Module: gsu_cache_ctrl

---
 rtl/gsu_pkg.sv | 18 +
 rtl/gsu_cache_valid.sv | 28 ++
 rtl/gsu_cache_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gsu_pkg.sv
// Shared definitions for the GSU instruction-cache controller: FSM states,
// default cache geometry and the SNES address of the cache RAM window.
package gsu_pkg;

  localparam int CACHE_LINES = 32;
  localparam int LINE_BYTES  = 16;

  localparam logic [15:0] CACHE_WIN_BASE = 16'h3100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_BYPASS = 3'd3,
    ST_DONE   = 3'd4
  } gsu_state_e;

endpackage

// File: rtl/gsu_cache_valid.sv
// Per-line valid bits. A flush clears every line and wins over a set that
// lands in the same cycle.
module gsu_cache_valid #(
  parameter int LINES = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_set,
  input  logic [$clog2(LINES)-1:0] i_set_idx,
  output logic [LINES-1:0]         o_valid
);

  logic [LINES-1:0] r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_set) begin
      r_valid[i_set_idx] <= 1'b1;
    end
  end

  assign o_valid = r_valid;

endmodule

// File: rtl/gsu_cache_ctrl.sv
// GSU opcode cache controller: serves core opcode fetches from the 512-byte
// cache RAM, fills whole lines from ROM on a miss, bypasses out-of-window PCs.
module gsu_cache_ctrl #(
  parameter int CACHE_LINES = gsu_pkg::CACHE_LINES,
  parameter int LINE_BYTES  = gsu_pkg::LINE_BYTES
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [7:0]             fetch_pbr,
  input  logic [15:0]            fetch_pc,
  input  logic [15:0]            cbr,
  input  logic                   cache_flush,
  output logic                   fetch_ack,
  output logic [7:0]             fetch_data,
  output logic                   rom_req,
  output logic [23:0]            rom_addr,
  input  logic                   rom_ack,
  input  logic [7:0]             rom_data,
  input  logic                   cpu_wr,
  input  logic [8:0]             cpu_addr,
  input  logic [7:0]             cpu_data,
  output logic [8:0]             cache_addr,
  output logic [7:0]             cache_din,
  output logic                   cache_we,
  input  logic [7:0]             cache_dout,
  output logic                   busy,
  output logic [2:0]             dbg_state,
  output logic [CACHE_LINES-1:0] dbg_valid
);

  import gsu_pkg::*;

  localparam int LINE_W = $clog2(CACHE_LINES);
  localparam int BYTE_W = $clog2(LINE_BYTES);
  localparam int OFF_W  = LINE_W + BYTE_W;
  localparam logic [15:0] WIN_BYTES = 16'(CACHE_LINES * LINE_BYTES);

  // Handshakes: fetch_req is held by the core until the one-cycle fetch_ack;
  // rom_req is held with a stable rom_addr until the cycle rom_ack is high,
  // and a request completes only in a cycle where both are high.

  gsu_state_e r_state;
  gsu_state_e w_next;

  logic [OFF_W-1:0]  r_offset;
  logic [BYTE_W-1:0] r_k;
  logic [1:0]        r_phase;
  logic              r_flushed;
  logic [7:0]        r_data;
  logic              r_rom_req;
  logic [23:0]       r_rom_addr;
  logic [8:0]        r_cache_addr;
  logic [7:0]        r_cache_din;
  logic              r_cache_we;

  logic [15:0]       w_offset;
  logic              w_in_range;
  logic [LINE_W-1:0] w_line;
  logic              w_line_valid;
  logic              w_rom_hs;
  logic              w_accept;
  logic              w_cpu_write;
  logic              w_set_valid;
  logic [LINE_W-1:0] w_set_idx;
  logic              w_unused;

  // Wrap-around subtraction: a PC below the base lands far out of the window.
  assign w_offset     = fetch_pc - {cbr[15:BYTE_W], {BYTE_W{1'b0}}};
  assign w_in_range   = (w_offset < WIN_BYTES);
  assign w_line       = r_offset[OFF_W-1:BYTE_W];
  assign w_line_valid = dbg_valid[w_line];
  assign w_rom_hs     = r_rom_req & rom_ack;
  assign w_unused     = &{1'b0, cbr[BYTE_W-1:0]};

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_cpu_write = 1'b0;
    w_set_valid = 1'b0;
    w_set_idx   = w_line;
    case (r_state)
      ST_IDLE: begin
        if (cpu_wr) begin
          w_cpu_write = 1'b1;
          if (cpu_addr[BYTE_W-1:0] == {BYTE_W{1'b1}}) begin
            w_set_valid = 1'b1;
            w_set_idx   = cpu_addr[OFF_W-1:BYTE_W];
          end
        end else if (fetch_req) begin
          w_accept = 1'b1;
          w_next   = w_in_range ? ST_LOOKUP : ST_BYPASS;
        end
      end
      ST_LOOKUP: begin
        if (r_phase == 2'd0 && !w_line_valid) begin
          w_next = ST_FILL;
        end else if (r_phase == 2'd2) begin
          w_next = ST_DONE;
        end
      end
      ST_FILL: begin
        if (w_rom_hs && r_k == {BYTE_W{1'b1}}) begin
          w_next      = ST_DONE;
          w_set_valid = !r_flushed;
        end
      end
      ST_BYPASS: begin
        if (w_rom_hs) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_offset     <= '0;
      r_k          <= '0;
      r_phase      <= '0;
      r_flushed    <= 1'b0;
      r_data       <= '0;
      r_rom_req    <= 1'b0;
      r_rom_addr   <= '0;
      r_cache_addr <= '0;
      r_cache_din  <= '0;
      r_cache_we   <= 1'b0;
    end else begin
      r_cache_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_phase <= '0;
          r_k     <= '0;
          if (w_cpu_write) begin
            r_cache_addr <= cpu_addr;
            r_cache_din  <= cpu_data;
            r_cache_we   <= 1'b1;
          end else if (w_accept) begin
            r_offset <= w_offset[OFF_W-1:0];
          end
        end
        ST_LOOKUP: begin
          // Address goes out in phase 0, RAM answers one cycle later.
          r_phase <= r_phase + 2'd1;
          if (r_phase == 2'd0) begin
            r_cache_addr <= r_offset;
          end
          if (r_phase == 2'd2) begin
            r_data <= cache_dout;
          end
        end
        ST_FILL: begin
          if (!r_rom_req) begin
            r_rom_req  <= 1'b1;
            r_rom_addr <= {fetch_pbr, fetch_pc[15:BYTE_W], r_k};
          end else if (rom_ack) begin
            r_rom_req    <= 1'b0;
            r_cache_addr <= {w_line, r_k};
            r_cache_din  <= rom_data;
            r_cache_we   <= 1'b1;
            r_k          <= r_k + 1'b1;
            if (r_k == fetch_pc[BYTE_W-1:0]) begin
              r_data <= rom_data;
            end
          end
        end
        ST_BYPASS: begin
          if (!r_rom_req) begin
            r_rom_req  <= 1'b1;
            r_rom_addr <= {fetch_pbr, fetch_pc};
          end else if (rom_ack) begin
            r_rom_req <= 1'b0;
            r_data    <= rom_data;
          end
        end
        default: begin
        end
      endcase
      // Remembers a flush seen mid-fetch so the line being filled stays invalid.
      if (r_state == ST_IDLE) begin
        r_flushed <= 1'b0;
      end else if (cache_flush) begin
        r_flushed <= 1'b1;
      end
    end
  end

  gsu_cache_valid #(
    .LINES(CACHE_LINES)
  ) u_valid (
    .i_clk    (clkin),
    .i_rst    (reset),
    .i_flush  (cache_flush),
    .i_set    (w_set_valid),
    .i_set_idx(w_set_idx),
    .o_valid  (dbg_valid)
  );

  assign fetch_ack  = (r_state == ST_DONE);
  assign fetch_data = r_data;
  assign rom_req    = r_rom_req;
  assign rom_addr   = r_rom_addr;
  assign cache_addr = r_cache_addr;
  assign cache_din  = r_cache_din;
  assign cache_we   = r_cache_we;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule
